// File: rtl/dmem_arbiter_if.sv
// rtl/dmem_arbiter_if.sv - requester, response and data-memory signal bundle for dmem_arbiter
interface dmem_arbiter_if;
    logic        req_valid_0;
    logic        req_valid_1;
    logic        req_we_0;
    logic        req_we_1;
    logic [31:0] req_addr_0;
    logic [31:0] req_addr_1;
    logic [31:0] req_wdata_0;
    logic [31:0] req_wdata_1;
    logic [2:0]  req_funct3_0;
    logic [2:0]  req_funct3_1;
    logic        req_ready_0;
    logic        req_ready_1;
    logic        rsp_valid_0;
    logic        rsp_valid_1;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        dm_mem_write;
    logic        dm_mem_read;
    logic [31:0] dm_address;
    logic [31:0] dm_write_data;
    logic [2:0]  dm_funct3;
    logic [31:0] dm_read_data;

    modport slave (
        input  req_valid_0, req_valid_1, req_we_0, req_we_1,
        input  req_addr_0, req_addr_1, req_wdata_0, req_wdata_1,
        input  req_funct3_0, req_funct3_1, dm_read_data,
        output req_ready_0, req_ready_1, rsp_valid_0, rsp_valid_1,
        output rsp_rdata, rsp_err,
        output dm_mem_write, dm_mem_read, dm_address, dm_write_data, dm_funct3
    );

    modport master (
        output req_valid_0, req_valid_1, req_we_0, req_we_1,
        output req_addr_0, req_addr_1, req_wdata_0, req_wdata_1,
        output req_funct3_0, req_funct3_1, dm_read_data,
        input  req_ready_0, req_ready_1, rsp_valid_0, rsp_valid_1,
        input  rsp_rdata, rsp_err,
        input  dm_mem_write, dm_mem_read, dm_address, dm_write_data, dm_funct3
    );
endinterface

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - round-robin two-port arbiter and access sequencer for the data memory
// Defining DMEM_ARB_CHECK_EN adds word-size, alignment and range checking of accepted requests.
module dmem_arbiter #(
    parameter int ADDR_LIMIT = 4096
) (
    input  logic          clk,
    input  logic          rst_n,
    dmem_arbiter_if.slave bus
);

`ifdef DMEM_ARB_CHECK_EN
    localparam bit CHECK_EN = 1'b1;
`else
    localparam bit CHECK_EN = 1'b0;
`endif
    localparam logic [31:0] LAST_WORD = 32'(ADDR_LIMIT - 4);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic        owner;
    logic        last_grant;
    logic        lat_we;
    logic        lat_err;
    logic [31:0] lat_addr;
    logic [31:0] lat_wdata;
    logic [2:0]  lat_funct3;
    logic [31:0] rsp_rdata_q;
    logic        rsp_err_q;

    logic        grant_valid;
    logic        grant_port;
    logic        win_we;
    logic [31:0] win_addr;
    logic [31:0] win_wdata;
    logic [2:0]  win_funct3;
    logic        win_err;

    // Grant depends only on request valids and last_grant, never on memory or response signals.
    always_comb begin
        state_nxt   = state;
        grant_valid = 1'b0;
        grant_port  = 1'b0;
        case (state)
            IDLE: begin
                if (rst_n) begin
                    if (bus.req_valid_0 && bus.req_valid_1) begin
                        grant_valid = 1'b1;
                        grant_port  = ~last_grant;
                    end else if (bus.req_valid_0) begin
                        grant_valid = 1'b1;
                        grant_port  = 1'b0;
                    end else if (bus.req_valid_1) begin
                        grant_valid = 1'b1;
                        grant_port  = 1'b1;
                    end
                end
                if (grant_valid) begin
                    state_nxt = ACCESS;
                end
            end
            ACCESS:  state_nxt = RESP;
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        win_we     = bus.req_we_0;
        win_addr   = bus.req_addr_0;
        win_wdata  = bus.req_wdata_0;
        win_funct3 = bus.req_funct3_0;
        if (grant_port) begin
            win_we     = bus.req_we_1;
            win_addr   = bus.req_addr_1;
            win_wdata  = bus.req_wdata_1;
            win_funct3 = bus.req_funct3_1;
        end
        win_err = CHECK_EN && ((win_funct3 != 3'b010) || (win_addr[1:0] != 2'b00) ||
                               (win_addr > LAST_WORD));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            owner       <= 1'b0;
            last_grant  <= 1'b1;
            lat_we      <= 1'b0;
            lat_err     <= 1'b0;
            lat_addr    <= '0;
            lat_wdata   <= '0;
            lat_funct3  <= '0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            if (grant_valid) begin
                owner      <= grant_port;
                lat_we     <= win_we;
                lat_err    <= win_err;
                lat_addr   <= win_addr;
                lat_wdata  <= win_wdata;
                lat_funct3 <= win_funct3;
            end
            // Stores and rejected accesses return zero data.
            if (state == ACCESS) begin
                last_grant  <= owner;
                rsp_rdata_q <= (lat_we || lat_err) ? 32'h0 : bus.dm_read_data;
                rsp_err_q   <= lat_err;
            end
        end
    end

    // Strobes decode straight from the state register so reset removes them asynchronously.
    assign bus.dm_mem_write  = (state == ACCESS) && lat_we && !lat_err;
    assign bus.dm_mem_read   = (state == ACCESS) && !lat_we && !lat_err;
    assign bus.dm_address    = lat_addr;
    assign bus.dm_write_data = lat_wdata;
    assign bus.dm_funct3     = lat_funct3;

    assign bus.req_ready_0   = grant_valid && !grant_port;
    assign bus.req_ready_1   = grant_valid && grant_port;
    assign bus.rsp_valid_0   = (state == RESP) && !owner;
    assign bus.rsp_valid_1   = (state == RESP) && owner;
    assign bus.rsp_rdata     = rsp_rdata_q;
    assign bus.rsp_err       = rsp_err_q;

endmodule
